// File: rtl/imu_sample_scheduler.sv
// imu_sample_scheduler
//
// Paces IMU reads on the IMU I2C bus at a fixed sample rate. A free-running slot counter
// (active while enable=1) produces one tick every PERIOD = CLK_HZ/SAMPLE_HZ cycles. On each
// tick the scheduler either issues a one-cycle read request, or counts the slot as an overrun
// if the IMU interface or the scheduler itself is still busy. A completed read is latched into
// six stable snapshot registers and announced with a one-cycle DataValid pulse. A read that
// never completes is abandoned after TIMEOUT_CYC cycles of waiting and counted as a timeout.
//
// Ports:
//   CLOCK_50             in   system clock, rising edge
//   RESET_N              in   asynchronous active-low reset
//   enable               in   1 = generate sample slots, 0 = pacing stopped
//   rd_start             out  one-cycle pulse, start one IMU read sequence
//   rd_busy              in   IMU interface busy with a transaction
//   rd_done              in   one-cycle pulse, axis inputs valid this cycle
//   AccelX_in..GyroZ_in  in   raw axis words from the IMU interface
//   AccelX..GyroZ        out  snapshot of the last completed read
//   DataValid            out  one-cycle pulse, snapshot updated
//   sample_seq           out  completed reads, wraps 255->0
//   overrun_cnt          out  missed sample slots, saturates at 255
//   timeout_cnt          out  abandoned reads, saturates at 255
//   sched_busy           out  1 while the scheduler is not idle

module imu_sample_scheduler #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SAMPLE_HZ   = 100,
    parameter int unsigned TIMEOUT_CYC = 500_000,
    parameter int unsigned DW          = 10
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    input  logic          enable,
    output logic          rd_start,
    input  logic          rd_busy,
    input  logic          rd_done,
    input  logic [DW-1:0] AccelX_in,
    input  logic [DW-1:0] AccelY_in,
    input  logic [DW-1:0] AccelZ_in,
    input  logic [DW-1:0] GyroX_in,
    input  logic [DW-1:0] GyroY_in,
    input  logic [DW-1:0] GyroZ_in,
    output logic [DW-1:0] AccelX,
    output logic [DW-1:0] AccelY,
    output logic [DW-1:0] AccelZ,
    output logic [DW-1:0] GyroX,
    output logic [DW-1:0] GyroY,
    output logic [DW-1:0] GyroZ,
    output logic          DataValid,
    output logic [7:0]    sample_seq,
    output logic [7:0]    overrun_cnt,
    output logic [7:0]    timeout_cnt,
    output logic          sched_busy
);

    localparam int unsigned Period    = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned SlotW     = (Period > 1) ? $clog2(Period) : 1;
    localparam int unsigned TimerW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SlotW-1:0]  SlotLast  = SlotW'(Period - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
    localparam int NumAxes = 6;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e            state_q;
    logic [SlotW-1:0]  slot_q;
    logic [TimerW-1:0] timer_q;
    logic              tick;
    logic              overrun_evt;
    logic              rd_start_q;
    logic              data_valid_q;
    logic              sched_busy_q;
    logic [7:0]        sample_seq_q;
    logic [7:0]        overrun_q;
    logic [7:0]        timeout_q;
    logic [DW-1:0]     axis_in [NumAxes];
    logic [DW-1:0]     axis_q  [NumAxes];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign axis_in[0] = AccelX_in;
    assign axis_in[1] = AccelY_in;
    assign axis_in[2] = AccelZ_in;
    assign axis_in[3] = GyroX_in;
    assign axis_in[4] = GyroY_in;
    assign axis_in[5] = GyroZ_in;

    // ------------------------------------------------------------------
    // Slot counter: 0..Period-1 while enabled, held at 0 otherwise.
    // ------------------------------------------------------------------
    assign tick = enable && (slot_q == SlotLast);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            slot_q <= '0;
        end else if (!enable || tick) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // A slot is missed whenever it cannot start a read: either a read of ours is still in
    // flight, or the IMU interface is busy with something else. Nothing is queued.
    assign overrun_evt = tick && ((state_q != StIdle) || rd_busy);

    // ------------------------------------------------------------------
    // Read sequencer with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            rd_start_q   <= 1'b0;
            data_valid_q <= 1'b0;
            sched_busy_q <= 1'b0;
            sample_seq_q <= '0;
            overrun_q    <= '0;
            timeout_q    <= '0;
            for (int i = 0; i < NumAxes; i++) begin
                axis_q[i] <= '0;
            end
        end else begin
            rd_start_q   <= 1'b0;
            data_valid_q <= 1'b0;

            if (overrun_evt) begin
                overrun_q <= sat_inc(overrun_q);
            end

            unique case (state_q)
                StIdle: begin
                    if (tick && !rd_busy) begin
                        state_q      <= StStart;
                        rd_start_q   <= 1'b1;
                        sched_busy_q <= 1'b1;
                    end
                end

                StStart: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end

                StWait: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (rd_done) begin
                        for (int i = 0; i < NumAxes; i++) begin
                            axis_q[i] <= axis_in[i];
                        end
                        data_valid_q <= 1'b1;
                        sample_seq_q <= sample_seq_q + 8'd1;
                        state_q      <= StIdle;
                        sched_busy_q <= 1'b0;
                    end else if (timer_q == TimerLast) begin
                        timeout_q    <= sat_inc(timeout_q);
                        state_q      <= StIdle;
                        sched_busy_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                default: begin
                    state_q      <= StIdle;
                    sched_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_start    = rd_start_q;
    assign DataValid   = data_valid_q;
    assign sched_busy  = sched_busy_q;
    assign sample_seq  = sample_seq_q;
    assign overrun_cnt = overrun_q;
    assign timeout_cnt = timeout_q;
    assign AccelX      = axis_q[0];
    assign AccelY      = axis_q[1];
    assign AccelZ      = axis_q[2];
    assign GyroX       = axis_q[3];
    assign GyroY       = axis_q[4];
    assign GyroZ       = axis_q[5];

endmodule
